// File: rtl/mips_isa_pkg.sv
// ---------------------------------------------------------------------------
// mips_isa_pkg
// Shared MIPS instruction-set definitions used by both the instruction
// writer (encode side) and the fetch/decode path (decode side):
//   - instruction format codes (R / I / J / illegal)
//   - bit positions of every instruction field in the 32-bit word
//   - the R-type primary opcode
//   - the writer FSM state encoding
// ---------------------------------------------------------------------------
package mips_isa_pkg;

    // Format selector codes carried on the fmt input
    localparam logic [1:0] FMT_R   = 2'd0;
    localparam logic [1:0] FMT_I   = 2'd1;
    localparam logic [1:0] FMT_J   = 2'd2;
    localparam logic [1:0] FMT_ILL = 2'd3;

    // Field positions inside the 32-bit instruction word
    localparam int OPC_MSB   = 32'd31;
    localparam int OPC_LSB   = 32'd26;
    localparam int RS_MSB    = 32'd25;
    localparam int RS_LSB    = 32'd21;
    localparam int RT_MSB    = 32'd20;
    localparam int RT_LSB    = 32'd16;
    localparam int RD_MSB    = 32'd15;
    localparam int RD_LSB    = 32'd11;
    localparam int SHAMT_MSB = 32'd10;
    localparam int SHAMT_LSB = 32'd6;
    localparam int FUNCT_MSB = 32'd5;
    localparam int FUNCT_LSB = 32'd0;
    localparam int IMM_MSB   = 32'd15;
    localparam int IMM_LSB   = 32'd0;
    localparam int TGT_MSB   = 32'd25;
    localparam int TGT_LSB   = 32'd0;

    // All R-type instructions share the zero primary opcode
    localparam logic [5:0] OPC_RTYPE = 6'b000000;

    // Writer session states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mips_instr_pack.sv
// ---------------------------------------------------------------------------
// mips_instr_pack
// Purely combinational encoder: places the decoded MIPS fields into a 32-bit
// instruction word according to the selected format.
// Ports:
//   fmt                      format selector (R/I/J/illegal)
//   opcode, rs, rt, rd,
//   shamt, funct, imm,
//   target                   instruction fields
//   word                     encoded instruction (zero for illegal fmt)
//   illegal                  high when fmt does not name a legal format
// ---------------------------------------------------------------------------
module mips_instr_pack
    import mips_isa_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // Field placement per format; R-type ignores the opcode input
    always_comb begin
        word    = 32'h0000_0000;
        illegal = 1'b0;
        case (fmt)
            FMT_R: begin
                word[OPC_MSB:OPC_LSB]     = OPC_RTYPE;
                word[RS_MSB:RS_LSB]       = rs;
                word[RT_MSB:RT_LSB]       = rt;
                word[RD_MSB:RD_LSB]       = rd;
                word[SHAMT_MSB:SHAMT_LSB] = shamt;
                word[FUNCT_MSB:FUNCT_LSB] = funct;
            end
            FMT_I: begin
                word[OPC_MSB:OPC_LSB] = opcode;
                word[RS_MSB:RS_LSB]   = rs;
                word[RT_MSB:RT_LSB]   = rt;
                word[IMM_MSB:IMM_LSB] = imm;
            end
            FMT_J: begin
                word[OPC_MSB:OPC_LSB] = opcode;
                word[TGT_MSB:TGT_LSB] = target;
            end
            FMT_ILL: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mips_instr_writer.sv
// ---------------------------------------------------------------------------
// mips_instr_writer
// Accepts decoded MIPS field bundles over a valid/ready handshake, encodes
// each into a 32-bit instruction and writes the words to consecutive
// instruction-memory addresses starting at a base latched on start.
// Ports:
//   clk, rst_n               clock; synchronous active-low reset
//   start, base_addr, length session start pulse, first byte address, words
//   in_valid / in_ready      field bundle handshake
//   fmt ... target           decoded instruction fields
//   mem_we, mem_addr,
//   mem_wdata, mem_ready     memory write port (held until mem_ready)
//   busy, done, err          status: active, one-cycle completion, sticky
//                            illegal-format flag
//   words_written            words committed in the current session
// ---------------------------------------------------------------------------
module mips_instr_writer
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  length,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  words_written
);

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(32'd4);

    state_t             state_r;
    logic [CNT_W-1:0]   remaining_r;
    logic [31:0]        pack_word_s;
    logic               pack_illegal_s;

    mips_instr_pack u_pack (
        .fmt     (fmt),
        .opcode  (opcode),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .funct   (funct),
        .imm     (imm),
        .target  (target),
        .word    (pack_word_s),
        .illegal (pack_illegal_s)
    );

    // Session FSM; every output is registered and updated alongside the state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            remaining_r   <= CNT_ZERO;
            in_ready      <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= ADDR_ZERO;
            mem_wdata     <= 32'h0000_0000;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            words_written <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done   <= 1'b0;
                    mem_we <= 1'b0;
                    if (start) begin
                        mem_addr      <= base_addr;
                        remaining_r   <= length;
                        err           <= 1'b0;
                        words_written <= CNT_ZERO;
                        busy          <= 1'b1;
                        if (length == CNT_ZERO) begin
                            // Empty session: report completion right away
                            state_r  <= ST_DONE;
                            done     <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            state_r  <= ST_ACCEPT;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        state_r  <= ST_IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b0;
                    end
                end
                ST_ACCEPT: begin
                    if (in_valid && in_ready) begin
                        if (pack_illegal_s) begin
                            // Bundle is swallowed; address and count untouched
                            err     <= 1'b1;
                            state_r <= ST_ACCEPT;
                        end else begin
                            mem_wdata <= pack_word_s;
                            mem_we    <= 1'b1;
                            in_ready  <= 1'b0;
                            state_r   <= ST_WRITE;
                        end
                    end else begin
                        state_r <= ST_ACCEPT;
                    end
                end
                ST_WRITE: begin
                    if (mem_ready) begin
                        mem_we      <= 1'b0;
                        mem_addr    <= mem_addr + ADDR_STEP;
                        remaining_r <= remaining_r - CNT_ONE;
                        if (words_written != CNT_MAX) begin
                            words_written <= words_written + CNT_ONE;
                        end else begin
                            words_written <= CNT_MAX;
                        end
                        if (remaining_r == CNT_ONE) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r  <= ST_ACCEPT;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        // Hold address/data/strobe until memory takes the word
                        state_r <= ST_WRITE;
                    end
                end
                ST_DONE: begin
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                    mem_we   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    in_ready <= 1'b0;
                    mem_we   <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_instr_writer.sv
// ---------------------------------------------------------------------------
// tb_mips_instr_writer
// Directed self-checking bench: expected (address, word) pairs are queued when
// a bundle is accepted and compared when the DUT commits a write.
// ---------------------------------------------------------------------------
module tb_mips_instr_writer;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;

    localparam logic [31:0] W_SUB = 32'h0232_9822;
    localparam logic [31:0] W_LW  = 32'h8E08_0004;
    localparam logic [31:0] W_J   = 32'h0800_0010;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  length;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [5:0]        opcode;
    logic [4:0]        rs, rt, rd, shamt;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic              busy, done, err;
    logic [CNT_W-1:0]  words_written;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int exp_done = 0;
    logic [ADDR_W-1:0] exp_addr;
    logic [63:0]       sb[$];
    logic [63:0]       sb_head;

    mips_instr_writer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .length        (length),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .fmt           (fmt),
        .opcode        (opcode),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .shamt         (shamt),
        .funct         (funct),
        .imm           (imm),
        .target        (target),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ready     (mem_ready),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: compare each committed write, count done pulses
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1 && mem_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {32'h0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                sb_head = sb.pop_front();
                check("wr_addr", {32'h0, mem_addr}, {32'h0, sb_head[63:32]});
                check("wr_data", {32'h0, mem_wdata}, {32'h0, sb_head[31:0]});
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, {63'h0, in_ready}, 64'h0);
        check({tag, "_mem_we"},   {63'h0, mem_we},   64'h0);
        check({tag, "_mem_addr"}, {32'h0, mem_addr}, 64'h0);
        check({tag, "_wdata"},    {32'h0, mem_wdata}, 64'h0);
        check({tag, "_busy"},     {63'h0, busy},     64'h0);
        check({tag, "_done"},     {63'h0, done},     64'h0);
        check({tag, "_err"},      {63'h0, err},      64'h0);
        check({tag, "_words"},    {48'h0, words_written}, 64'h0);
    endtask

    // Pulse start for one cycle; returns 1 time unit after the sampling edge
    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] l);
        start = 1'b1; base_addr = b; length = l;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = b;
    endtask

    // Present one bundle and hold it until accepted (bounded)
    task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                        input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg,
                        input logic [31:0] exp_word);
        bit accepted = 1'b0;
        fmt = f; opcode = op; rs = s; rt = t; rd = d; shamt = sh;
        funct = fn; imm = im; target = tg; in_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (in_ready === 1'b1) accepted = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            check("send_timeout", 64'h0, 64'h1);
        end else if (f != 2'd3) begin
            sb.push_back({exp_addr, exp_word});
            exp_addr = exp_addr + 32'd4;
        end
    endtask

    task automatic send_sub(input logic [31:0] w);
        send(2'd0, 6'h3F, 5'd17, 5'd18, 5'd19, 5'd0, 6'h22, 16'hFFFF, 26'h3FF_FFFF, w);
    endtask

    task automatic wait_idle(input string tag);
        bit idle = 1'b0;
        for (int i = 0; i < 50 && !idle; i++) begin
            @(posedge clk); #1;
            if (busy === 1'b0) idle = 1'b1;
        end
        if (!idle) check({tag, "_idle_timeout"}, 64'h0, 64'h1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
        in_valid = 1'b0; fmt = 2'd0; opcode = 6'd0; rs = 5'd0; rt = 5'd0;
        rd = 5'd0; shamt = 5'd0; funct = 6'd0; imm = 16'd0; target = 26'd0;
        mem_ready = 1'b1; exp_addr = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single R-type word
        do_start(32'h0040_0000, 16'd1);
        check("t1_busy", {63'h0, busy}, 64'h1);
        send_sub(W_SUB);
        wait_idle("t1");
        exp_done++;
        check("t1_done_cnt", 64'(done_cnt), 64'(exp_done));
        check("t1_words", {48'h0, words_written}, 64'd1);
        check("t1_addr", {32'h0, mem_addr}, 64'h0040_0004);

        // Three formats back to back, plus a start pulse while busy
        do_start(32'h0000_1000, 16'd3);
        send(2'd1, 6'h23, 5'd16, 5'd8, 5'd31, 5'd31, 6'h3F, 16'h0004, 26'h3FF_FFFF, W_LW);
        start = 1'b1; base_addr = 32'hDEAD_0000; length = 16'd7;
        @(posedge clk); #1;
        start = 1'b0;
        send(2'd2, 6'h02, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h000_0010, W_J);
        send_sub(W_SUB);
        wait_idle("t2");
        exp_done++;
        check("t2_done_cnt", 64'(done_cnt), 64'(exp_done));
        check("t2_words", {48'h0, words_written}, 64'd3);
        check("t2_addr", {32'h0, mem_addr}, 64'h0000_100C);

        // Memory back-pressure holds the write stable
        mem_ready = 1'b0;
        do_start(32'h0000_3000, 16'd1);
        send_sub(W_SUB);
        for (int i = 0; i < 5; i++) begin
            check("stall_we",    {63'h0, mem_we},      64'h1);
            check("stall_addr",  {32'h0, mem_addr},    64'h0000_3000);
            check("stall_data",  {32'h0, mem_wdata},   {32'h0, W_SUB});
            check("stall_ready", {63'h0, in_ready},    64'h0);
            @(posedge clk); #1;
        end
        check("stall_words", {48'h0, words_written}, 64'd0);
        mem_ready = 1'b1;
        wait_idle("stall");
        exp_done++;
        check("stall_words_after", {48'h0, words_written}, 64'd1);
        check("stall_addr_after", {32'h0, mem_addr}, 64'h0000_3004);

        // Illegal bundle between two legal ones
        do_start(32'h0000_4000, 16'd2);
        check("ill_err_clear0", {63'h0, err}, 64'h0);
        send_sub(W_SUB);
        send(2'd3, 6'h23, 5'd16, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0004, 26'h0, 32'h0);
        check("ill_err_set", {63'h0, err}, 64'h1);
        check("ill_words_mid", {48'h0, words_written}, 64'd1);
        send(2'd1, 6'h23, 5'd16, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0004, 26'h0, W_LW);
        wait_idle("ill");
        exp_done++;
        check("ill_words", {48'h0, words_written}, 64'd2);
        check("ill_err_sticky", {63'h0, err}, 64'h1);
        check("ill_addr", {32'h0, mem_addr}, 64'h0000_4008);

        // Zero-length session: clears err, done one cycle later, no write
        do_start(32'h0000_5000, 16'd0);
        check("len0_done", {63'h0, done}, 64'h1);
        check("len0_we", {63'h0, mem_we}, 64'h0);
        check("len0_err_clear", {63'h0, err}, 64'h0);
        @(posedge clk); #1;
        check("len0_done_drop", {63'h0, done}, 64'h0);
        check("len0_busy", {63'h0, busy}, 64'h0);
        exp_done++;

        // Address wrap-around
        do_start(32'hFFFF_FFFC, 16'd2);
        send_sub(W_SUB);
        send(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h000_0010, W_J);
        wait_idle("wrap");
        exp_done++;
        check("wrap_addr", {32'h0, mem_addr}, 64'h0000_0004);
        check("wrap_done_cnt", 64'(done_cnt), 64'(exp_done));

        // Reset during a stalled write abandons the session
        mem_ready = 1'b0;
        do_start(32'h0000_6000, 16'd2);
        send_sub(W_SUB);
        check("rstw_we_before", {63'h0, mem_we}, 64'h1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        check_reset_state("rstw");
        rst_n = 1'b1;
        mem_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rstw_we_after", {63'h0, mem_we}, 64'h0);
        check("rstw_busy_after", {63'h0, busy}, 64'h0);

        check("final_done_cnt", 64'(done_cnt), 64'(exp_done));
        check("final_sb_empty", 64'(sb.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_instr_writer.md
Name: mips_instr_writer

Overview:
Write-side partner to the instruction fetch/decode path. It accepts decoded MIPS instruction fields (R/I/J format) through a valid/ready handshake and packs each one into a 32-bit instruction word. It then writes the words sequentially into instruction memory, starting at a programmed base address. The decode path later reads these words back and splits them into opcode/function fields.

Parameters:
ADDR_W, 32, byte-address width of instruction memory port
CNT_W, 16, width of the word-length and word-count counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
start  in  1  one-cycle pulse; begins a load session (ignored unless IDLE)
base_addr  in  ADDR_W  first byte address of session; latched on start
length  in  CNT_W  number of words to write; latched on start
in_valid  in  1  field bundle valid
in_ready  out  1  block can accept a bundle
fmt  in  2  0=R, 1=I, 2=J, 3=illegal
opcode  in  6  primary opcode (ignored for R, which forces 6'b000000)
rs  in  5  source register
rt  in  5  target register
rd  in  5  destination register (R only)
shamt  in  5  shift amount (R only)
funct  in  6  function code (R only)
imm  in  16  immediate (I only)
target  in  26  jump target (J only)
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  write byte address
mem_wdata  out  32  encoded instruction
mem_ready  in  1  memory accepts the write this cycle
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the session completes
err  out  1  sticky illegal-format flag; cleared on start
words_written  out  CNT_W  words committed in the current session

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, words_written=0. Reset mid-session abandons the session; any pending write is dropped with no further mem_we.
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE:
  - start=1 latches base_addr into the address register and length into the remaining-word counter, clears err and words_written.
  - If length==0, go to DONE; otherwise go to ACCEPT.
- ACCEPT:
  - in_ready=1. On in_valid&&in_ready, register the encoded word into mem_wdata.
  - fmt 0 (R): {6'b0, rs, rt, rd, shamt, funct}.
  - fmt 1 (I): {opcode, rs, rt, imm}.
  - fmt 2 (J): {opcode, target}.
  - fmt 3 (illegal): bundle is consumed, err<=1, no write, no address or count change; stay in ACCEPT.
  - For a legal fmt, go to WRITE.
- WRITE:
  - mem_we=1; mem_addr and mem_wdata are held stable until mem_ready=1.
  - On mem_ready: mem_addr += 4 (wraps modulo 2^ADDR_W), words_written += 1, remaining -= 1.
  - If remaining was 1, go to DONE; otherwise go to ACCEPT.
  - in_ready=0 throughout.
- DONE: done=1 for exactly one cycle, then IDLE. mem_addr holds the next free address.
- Latency: bundle accept to first mem_we is 1 cycle. Minimum of 2 cycles per word at mem_ready=1.
- start while busy: ignored, no effect.
- in_valid outside ACCEPT: ignored; the source holds the bundle until in_ready.
- words_written saturates at 2^CNT_W-1; unreachable when length fits in CNT_W.

Decomposition:
- Shared package mips_isa_pkg holds:
  - format codes FMT_R/FMT_I/FMT_J/FMT_ILL;
  - field-position constants (OPC_MSB=31, RS 25:21, RT 20:16, RD 15:11, SHAMT 10:6, FUNCT 5:0, IMM 15:0, TGT 25:0);
  - OPC_RTYPE=6'b000000;
  - the state enum.
- The decode path uses the same package.
- One combinational sub-module, mips_instr_pack (fields+fmt in, 32-bit word + illegal flag out).
- The FSM, address register and counters stay in the top.

Test Plan:
- start base=0x00400000, len=1; R bundle rs=17, rt=18, rd=19, shamt=0, funct=0x22, mem_ready=1 -> one write of 0x02329822 at 0x00400000, done pulse, words_written=1, mem_addr=0x00400004.
- len=3; bundles in order:
  - I: opcode 0x23, rs=16, rt=8, imm=4;
  - J: opcode 2, target 0x10;
  - R: sub as above.
  - Required -> writes 0x8E080004 @base, 0x08000010 @base+4, 0x02329822 @base+8; one done pulse.
- mem_ready held low 5 cycles during WRITE -> mem_we, mem_addr and mem_wdata stay constant for all 5 cycles; in_ready=0; single commit when mem_ready rises.
- len=2; illegal fmt=3 bundle between two legal ones -> err=1, only 2 writes, at consecutive addresses; next start clears err.
- base=0xFFFFFFFC, len=2 -> writes at 0xFFFFFFFC then 0x00000000; len=0 -> done after 1 cycle with no mem_we.
- rst_n=0 asserted in WRITE with mem_ready=0 -> next cycle state IDLE, all outputs at reset values, no further mem_we; start during busy -> ignored.
